// File: rtl/z80_bus_pkg.sv
// Shared types and widths for the tv80s bus responder.
// Bus cycle classes, responder FSM states and the latched request payload.
package z80_bus_pkg;

   localparam int unsigned WAIT_W = 3;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 8;

   typedef enum logic [2:0] {
      NONE,
      MRD,
      MWR,
      IORD,
      IOWR,
      INTA
   } bus_cls_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACCESS,
      ST_CAPTURE,
      ST_HOLD
   } resp_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      bus_cls_t          cls;
   } bus_req_t;

endpackage

// File: rtl/z80_bus_decode.sv
// Registers the CPU pins once and classifies the bus cycle from the registered copies.
// Classification outputs (_c) are combinational on registered state only.
module z80_bus_decode
   import z80_bus_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       A,
   input  logic [7:0]        dout,
   input  logic              m1_n,
   input  logic              mreq_n,
   input  logic              iorq_n,
   input  logic              rd_n,
   input  logic              wr_n,
   input  logic              rfsh_n,
   output logic [15:0]       s_addr,
   output logic [7:0]        s_data,
   output logic [2:0]        cls_c,
   output logic              rw_err_c,
   output logic              mi_err_c,
   output logic              all_high_c
);

   logic s_m1_n, s_mreq_n, s_iorq_n, s_rd_n, s_wr_n, s_rfsh_n;

   // Strobes reset to "asserted" so nothing can arm until real idle pins are seen.
   always_ff @(posedge clk) begin
      if (reset) begin
         s_m1_n   <= 1'b0;
         s_mreq_n <= 1'b0;
         s_iorq_n <= 1'b0;
         s_rd_n   <= 1'b0;
         s_wr_n   <= 1'b0;
         s_rfsh_n <= 1'b0;
         s_addr   <= '0;
         s_data   <= '0;
      end else begin
         s_m1_n   <= m1_n;
         s_mreq_n <= mreq_n;
         s_iorq_n <= iorq_n;
         s_rd_n   <= rd_n;
         s_wr_n   <= wr_n;
         s_rfsh_n <= rfsh_n;
         s_addr   <= A;
         s_data   <= dout;
      end
   end

   // Memory wins over I/O; refresh and rd/wr contention never produce a class.
   always_comb begin
      cls_c    = NONE;
      rw_err_c = 1'b0;
      mi_err_c = 1'b0;
      if (!(!s_mreq_n && !s_rfsh_n) && (!s_mreq_n || !s_iorq_n)) begin
         if (!s_rd_n && !s_wr_n) begin
            rw_err_c = 1'b1;
         end else if (!s_mreq_n) begin
            mi_err_c = !s_iorq_n && (!s_rd_n || !s_wr_n);
            if (!s_rd_n)      cls_c = MRD;
            else if (!s_wr_n) cls_c = MWR;
         end else if (!s_m1_n) begin
            cls_c = INTA;
         end else if (!s_rd_n) begin
            cls_c = IORD;
         end else if (!s_wr_n) begin
            cls_c = IOWR;
         end
      end
   end

   assign all_high_c = s_rd_n && s_wr_n && s_mreq_n && s_iorq_n;

endmodule

// File: rtl/z80_bus_responder.sv
// Target end of the tv80s pin bus: one RAM or I/O access per CPU strobe assertion,
// with programmable wait states and registered read data.
module z80_bus_responder
   import z80_bus_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 0,
   parameter int unsigned IO_WAIT  = 1,
   parameter logic [7:0]  IM2_VEC  = 8'hFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] A,
   input  logic [7:0]  dout,
   input  logic        m1_n,
   input  logic        mreq_n,
   input  logic        iorq_n,
   input  logic        rd_n,
   input  logic        wr_n,
   input  logic        rfsh_n,
   output logic [7:0]  di,
   output logic        wait_n,
   output logic [15:0] ram_addr,
   output logic [7:0]  ram_wdata,
   output logic        ram_re,
   output logic        ram_we,
   input  logic [7:0]  ram_rdata,
   output logic [7:0]  io_addr,
   output logic [7:0]  io_wdata,
   output logic        io_rd,
   output logic        io_wr,
   input  logic [7:0]  io_rdata,
   output logic        bus_err
);

   logic [15:0]       s_addr;
   logic [7:0]        s_data;
   logic [2:0]        cls_raw;
   logic              rw_err_c, mi_err_c, all_high_c;
   bus_cls_t          cls_c;
   bus_cls_t          acc_cls_c;
   resp_state_t       state, next_state;
   bus_req_t          req;
   logic [WAIT_W-1:0] wcnt;
   logic [WAIT_W-1:0] load_wait_c;
   logic              armed;
   logic              detect_c;
   logic              enter_access_c;
   logic [7:0]        io_cap;
   logic [7:0]        di_d;
   logic              wait_n_d, ram_re_d, ram_we_d, io_rd_d, io_wr_d;

   z80_bus_decode u_decode (
      .clk        (clk),
      .reset      (reset),
      .A          (A),
      .dout       (dout),
      .m1_n       (m1_n),
      .mreq_n     (mreq_n),
      .iorq_n     (iorq_n),
      .rd_n       (rd_n),
      .wr_n       (wr_n),
      .rfsh_n     (rfsh_n),
      .s_addr     (s_addr),
      .s_data     (s_data),
      .cls_c      (cls_raw),
      .rw_err_c   (rw_err_c),
      .mi_err_c   (mi_err_c),
      .all_high_c (all_high_c)
   );

   assign cls_c       = bus_cls_t'(cls_raw);
   assign detect_c    = (state == ST_IDLE) && armed && ((cls_c != NONE) || rw_err_c);
   assign load_wait_c = ((cls_c == MRD) || (cls_c == MWR)) ? WAIT_W'(MEM_WAIT) : WAIT_W'(IO_WAIT);

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (detect_c) begin
               if (rw_err_c)                  next_state = ST_HOLD;
               else if (load_wait_c != '0)    next_state = ST_WAIT;
               else                           next_state = ST_ACCESS;
            end
         end
         ST_WAIT:    if (wcnt == WAIT_W'(1)) next_state = ST_ACCESS;
         ST_ACCESS:  next_state = ST_CAPTURE;
         ST_CAPTURE: next_state = ST_HOLD;
         ST_HOLD:    if (all_high_c) next_state = ST_IDLE;
         default:    next_state = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs; the class comes straight from decode
   // when ACCESS is entered directly from IDLE.
   assign acc_cls_c      = (state == ST_IDLE) ? cls_c : req.cls;
   assign enter_access_c = (next_state == ST_ACCESS) && (state != ST_ACCESS);

   always_comb begin
      di_d     = di;
      wait_n_d = !((next_state == ST_WAIT) || (next_state == ST_ACCESS) ||
                   (next_state == ST_CAPTURE));
      ram_re_d = enter_access_c && (acc_cls_c == MRD);
      ram_we_d = enter_access_c && (acc_cls_c == MWR);
      io_rd_d  = enter_access_c && (acc_cls_c == IORD);
      io_wr_d  = enter_access_c && (acc_cls_c == IOWR);
      if (state == ST_CAPTURE) begin
         case (req.cls)
            MRD:     di_d = ram_rdata;
            IORD:    di_d = io_cap;
            INTA:    di_d = IM2_VEC;
            default: di_d = di;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         req     <= '{addr: '0, data: '0, cls: NONE};
         wcnt    <= '0;
         armed   <= 1'b0;
         io_cap  <= '0;
         bus_err <= 1'b0;
         di      <= 8'hFF;
         wait_n  <= 1'b1;
         ram_re  <= 1'b0;
         ram_we  <= 1'b0;
         io_rd   <= 1'b0;
         io_wr   <= 1'b0;
      end else begin
         di     <= di_d;
         wait_n <= wait_n_d;
         ram_re <= ram_re_d;
         ram_we <= ram_we_d;
         io_rd  <= io_rd_d;
         io_wr  <= io_wr_d;
         if (detect_c) begin
            req   <= '{addr: s_addr, data: s_data, cls: cls_c};
            wcnt  <= load_wait_c;
            armed <= 1'b0;
            if (rw_err_c || mi_err_c) bus_err <= 1'b1;
         end else if (((state == ST_IDLE) || (state == ST_HOLD)) && all_high_c) begin
            armed <= 1'b1;
         end
         if (state == ST_WAIT)   wcnt   <= wcnt - WAIT_W'(1);
         if (state == ST_ACCESS) io_cap <= io_rdata;
      end
   end

   assign ram_addr  = req.addr;
   assign ram_wdata = req.data;
   assign io_addr   = req.addr[7:0];
   assign io_wdata  = req.data;

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench for z80_bus_responder with a small RAM model (MEM_WAIT=0, IO_WAIT=3).
module tb_z80_bus_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] A;
   logic [7:0]  dout;
   logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
   logic [7:0]  di;
   logic        wait_n;
   logic [15:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic        ram_re, ram_we;
   logic [7:0]  ram_rdata;
   logic [7:0]  io_addr, io_wdata;
   logic        io_rd, io_wr;
   logic [7:0]  io_rdata;
   logic        bus_err;

   logic [7:0]  mem [0:65535];
   logic        pk_en = 1'b0;
   logic [15:0] pk_a = '0;
   logic [7:0]  pk_d = '0;

   int passed = 0;
   int total  = 0;

   int          n_re, n_we, n_iord, n_iowr, n_wlow;
   int          k_re, k_we, k_io, k_wl;
   logic [15:0] a_re, a_we;
   logic [7:0]  d_we, a_io, d_io;
   logic [7:0]  di_hist [0:15];

   always #5 clk = ~clk;

   z80_bus_responder #(.MEM_WAIT(0), .IO_WAIT(3), .IM2_VEC(8'hFF)) dut (
      .clk(clk), .reset(reset), .A(A), .dout(dout),
      .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n),
      .di(di), .wait_n(wait_n), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_re(ram_re), .ram_we(ram_we), .ram_rdata(ram_rdata),
      .io_addr(io_addr), .io_wdata(io_wdata), .io_rd(io_rd), .io_wr(io_wr),
      .io_rdata(io_rdata), .bus_err(bus_err)
   );

   // Synchronous RAM: read data one cycle after ram_re; bench preload port.
   always @(posedge clk) begin
      if (pk_en)  mem[pk_a] <= pk_d;
      if (ram_we) mem[ram_addr] <= ram_wdata;
      if (ram_re) ram_rdata <= mem[ram_addr];
   end

   task automatic poke(input logic [15:0] a, input logic [7:0] d);
      pk_en = 1'b1; pk_a = a; pk_d = d;
      @(posedge clk); #1;
      pk_en = 1'b0;
   endtask

   task automatic idle_bus();
      m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Runs ncyc clocks, logging strobes/wait/di; releases the bus after edge rel.
   task automatic observe(input int ncyc, input int rel);
      n_re = 0; n_we = 0; n_iord = 0; n_iowr = 0; n_wlow = 0;
      k_re = -1; k_we = -1; k_io = -1; k_wl = -1;
      for (int k = 1; k <= ncyc; k++) begin
         @(posedge clk); #1;
         di_hist[k] = di;
         if (ram_re) begin n_re++; k_re = k; a_re = ram_addr; end
         if (ram_we) begin n_we++; k_we = k; a_we = ram_addr; d_we = ram_wdata; end
         if (io_rd)  begin n_iord++; k_io = k; a_io = io_addr; end
         if (io_wr)  begin n_iowr++; k_io = k; a_io = io_addr; d_io = io_wdata; end
         if (!wait_n) begin if (n_wlow == 0) k_wl = k; n_wlow++; end
         if (k == rel) idle_bus();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; A = 16'h0000; dout = 8'h00; io_rdata = 8'h00;
      idle_bus(); mreq_n = 1'b0; rd_n = 1'b0;
      poke(16'h0000, 8'hCD);
      poke(16'hB07C, 8'hFF);
      poke(16'hB07B, 8'hFF);
      poke(16'h0010, 8'h3C);
      #1 reset = 1'b0;
      total++; if (di !== 8'hFF)  $display("FAIL reset_di got %h exp ff", di); else passed++;
      total++; if (wait_n !== 1'b1) $display("FAIL reset_wait_n got %b exp 1", wait_n); else passed++;
      total++; if (ram_re !== 1'b0) $display("FAIL reset_ram_re got %b exp 0", ram_re); else passed++;
      total++; if (bus_err !== 1'b0) $display("FAIL reset_bus_err got %b exp 0", bus_err); else passed++;
      observe(5, 0);
      total++; if (n_re !== 0) $display("FAIL reset_held_no_read got %0d exp 0", n_re); else passed++;
      total++; if (n_wlow !== 0) $display("FAIL reset_held_no_wait got %0d exp 0", n_wlow); else passed++;
      idle_bus();
      observe(4, 0);
      total++; if (n_re !== 0) $display("FAIL reset_release_no_read got %0d exp 0", n_re); else passed++;
      total++; if (di !== 8'hFF) $display("FAIL reset_release_di got %h exp ff", di); else passed++;
   endtask

   task automatic test_mem_read();
      A = 16'h0000; mreq_n = 1'b0; rd_n = 1'b0;
      observe(8, 2);
      total++; if (n_re !== 1) $display("FAIL mrd_count got %0d exp 1", n_re); else passed++;
      total++; if (k_re !== 2) $display("FAIL mrd_strobe_cycle got %0d exp 2", k_re); else passed++;
      total++; if (a_re !== 16'h0000) $display("FAIL mrd_addr got %h exp 0000", a_re); else passed++;
      total++; if (di_hist[3] !== 8'hFF) $display("FAIL mrd_di_early got %h exp ff", di_hist[3]); else passed++;
      total++; if (di_hist[4] !== 8'hCD) $display("FAIL mrd_di got %h exp cd", di_hist[4]); else passed++;
      total++; if (n_wlow !== 2) $display("FAIL mrd_wait_len got %0d exp 2", n_wlow); else passed++;
      total++; if (k_wl !== 2) $display("FAIL mrd_wait_start got %0d exp 2", k_wl); else passed++;
   endtask

   task automatic test_back_to_back();
      A = 16'hB07C; dout = 8'h00; mreq_n = 1'b0; wr_n = 1'b0;
      observe(10, 5);
      total++; if (n_we !== 1) $display("FAIL push1_count got %0d exp 1", n_we); else passed++;
      total++; if (k_we !== 2) $display("FAIL push1_cycle got %0d exp 2", k_we); else passed++;
      total++; if (a_we !== 16'hB07C) $display("FAIL push1_addr got %h exp b07c", a_we); else passed++;
      total++; if (mem[16'hB07C] !== 8'h00) $display("FAIL push1_ram got %h exp 00", mem[16'hB07C]); else passed++;
      A = 16'hB07B; dout = 8'h03; mreq_n = 1'b0; wr_n = 1'b0;
      observe(10, 5);
      total++; if (n_we !== 1) $display("FAIL push2_count got %0d exp 1", n_we); else passed++;
      total++; if (d_we !== 8'h03) $display("FAIL push2_wdata got %h exp 03", d_we); else passed++;
      total++; if (mem[16'hB07B] !== 8'h03) $display("FAIL push2_ram got %h exp 03", mem[16'hB07B]); else passed++;
      total++; if (di_hist[10] !== 8'hCD) $display("FAIL push_di_kept got %h exp cd", di_hist[10]); else passed++;
   endtask

   task automatic test_io();
      A = 16'h1234; io_rdata = 8'h5A; iorq_n = 1'b0; rd_n = 1'b0;
      observe(12, 2);
      total++; if (n_iord !== 1) $display("FAIL iord_count got %0d exp 1", n_iord); else passed++;
      total++; if (k_io !== 5) $display("FAIL iord_cycle got %0d exp 5", k_io); else passed++;
      total++; if (a_io !== 8'h34) $display("FAIL iord_addr got %h exp 34", a_io); else passed++;
      total++; if (n_wlow !== 5) $display("FAIL iord_wait_len got %0d exp 5", n_wlow); else passed++;
      total++; if (di_hist[6] !== 8'hCD) $display("FAIL iord_di_early got %h exp cd", di_hist[6]); else passed++;
      total++; if (di_hist[7] !== 8'h5A) $display("FAIL iord_di got %h exp 5a", di_hist[7]); else passed++;
      total++; if (n_re !== 0) $display("FAIL iord_no_ram got %0d exp 0", n_re); else passed++;
      io_rdata = 8'h00;
      A = 16'h0056; dout = 8'h77; iorq_n = 1'b0; wr_n = 1'b0;
      observe(12, 2);
      total++; if (n_iowr !== 1) $display("FAIL iowr_count got %0d exp 1", n_iowr); else passed++;
      total++; if (k_io !== 5) $display("FAIL iowr_cycle got %0d exp 5", k_io); else passed++;
      total++; if (d_io !== 8'h77) $display("FAIL iowr_wdata got %h exp 77", d_io); else passed++;
      total++; if (di_hist[12] !== 8'h5A) $display("FAIL iowr_di_kept got %h exp 5a", di_hist[12]); else passed++;
   endtask

   task automatic test_inta();
      A = 16'h0038; m1_n = 1'b0; iorq_n = 1'b0;
      observe(12, 2);
      total++; if (n_re + n_we + n_iord + n_iowr !== 0)
         $display("FAIL inta_strobes got %0d exp 0", n_re + n_we + n_iord + n_iowr); else passed++;
      total++; if (n_wlow !== 5) $display("FAIL inta_wait_len got %0d exp 5", n_wlow); else passed++;
      total++; if (di_hist[7] !== 8'hFF) $display("FAIL inta_di got %h exp ff", di_hist[7]); else passed++;
   endtask

   task automatic test_refresh_and_conflict();
      A = 16'h0010; mreq_n = 1'b0; rfsh_n = 1'b0;
      observe(6, 2);
      total++; if (n_re !== 0) $display("FAIL rfsh_no_read got %0d exp 0", n_re); else passed++;
      total++; if (n_wlow !== 0) $display("FAIL rfsh_no_wait got %0d exp 0", n_wlow); else passed++;
      total++; if (bus_err !== 1'b0) $display("FAIL rfsh_bus_err got %b exp 0", bus_err); else passed++;
      A = 16'h0010; mreq_n = 1'b0; iorq_n = 1'b0; rd_n = 1'b0;
      observe(8, 2);
      total++; if (n_re !== 1) $display("FAIL both_read_count got %0d exp 1", n_re); else passed++;
      total++; if (n_iord !== 0) $display("FAIL both_no_io got %0d exp 0", n_iord); else passed++;
      total++; if (di_hist[4] !== 8'h3C) $display("FAIL both_di got %h exp 3c", di_hist[4]); else passed++;
      total++; if (bus_err !== 1'b1) $display("FAIL both_bus_err got %b exp 1", bus_err); else passed++;
      A = 16'h0000; mreq_n = 1'b0; rd_n = 1'b0;
      observe(8, 2);
      total++; if (di_hist[4] !== 8'hCD) $display("FAIL sticky_read_di got %h exp cd", di_hist[4]); else passed++;
      total++; if (bus_err !== 1'b1) $display("FAIL sticky_bus_err got %b exp 1", bus_err); else passed++;
   endtask

   task automatic test_rw_conflict();
      do_reset();
      total++; if (bus_err !== 1'b0) $display("FAIL rst_clears_err got %b exp 0", bus_err); else passed++;
      A = 16'h0000; dout = 8'h99; mreq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
      observe(8, 2);
      total++; if (n_re + n_we !== 0) $display("FAIL rw_no_access got %0d exp 0", n_re + n_we); else passed++;
      total++; if (n_wlow !== 0) $display("FAIL rw_no_wait got %0d exp 0", n_wlow); else passed++;
      total++; if (bus_err !== 1'b1) $display("FAIL rw_bus_err got %b exp 1", bus_err); else passed++;
      total++; if (mem[16'h0000] !== 8'hCD) $display("FAIL rw_ram_intact got %h exp cd", mem[16'h0000]); else passed++;
      A = 16'h0010; mreq_n = 1'b0; rd_n = 1'b0;
      observe(8, 2);
      total++; if (n_re !== 1) $display("FAIL rw_recover_read got %0d exp 1", n_re); else passed++;
      total++; if (di_hist[4] !== 8'h3C) $display("FAIL rw_recover_di got %h exp 3c", di_hist[4]); else passed++;
   endtask

   initial begin
      test_reset();
      test_mem_read();
      test_back_to_back();
      test_io();
      test_inta();
      test_refresh_and_conflict();
      test_rw_conflict();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
